// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunk-pipelined two's-complement add/sub with saturation, flags and stall handshake
module pipelined_addsub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int NSTAGE = WIDTH / CHUNK;
   logic             adv;
   logic [WIDTH-1:0] be;
   logic [CHUNK-1:0] fa, fb;
   logic             fc, fv, fsub, fsat, fo;
   logic [CHUNK:0]   top;
   logic [WIDTH-1:0] raw;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign be       = b ^ {WIDTH{sub}};
   for (genvar k = 0; k < NSTAGE - 1; k++) begin : g_st
      localparam int UW = WIDTH - (k + 1) * CHUNK;
      localparam int LW = (k + 1) * CHUNK;
      logic          v, sb, st, c;
      logic [UW-1:0] au, bu;
      logic [LW-1:0] ps;
      if (k == 0) begin : g_first
         // resolve slice 0 straight from the ports, skew the upper operand slices
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               v  <= 1'b0;
               sb <= 1'b0;
               st <= 1'b0;
               c  <= 1'b0;
               au <= '0;
               bu <= '0;
               ps <= '0;
            end else if (adv) begin
               v       <= in_valid;
               sb      <= sub;
               st      <= sat;
               {c, ps} <= {1'b0, a[CHUNK-1:0]} + {1'b0, be[CHUNK-1:0]} + {{CHUNK{1'b0}}, sub};
               au      <= a[WIDTH-1:CHUNK];
               bu      <= be[WIDTH-1:CHUNK];
            end
      end else begin : g_mid
         // resolve slice k with the registered carry, deskew the finished lower sum
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               v  <= 1'b0;
               sb <= 1'b0;
               st <= 1'b0;
               c  <= 1'b0;
               au <= '0;
               bu <= '0;
               ps <= '0;
            end else if (adv) begin
               v  <= g_st[k-1].v;
               sb <= g_st[k-1].sb;
               st <= g_st[k-1].st;
               {c, ps[LW-1:LW-CHUNK]} <= {1'b0, g_st[k-1].au[CHUNK-1:0]} + {1'b0, g_st[k-1].bu[CHUNK-1:0]}
                                         + {{CHUNK{1'b0}}, g_st[k-1].c};
               ps[LW-CHUNK-1:0] <= g_st[k-1].ps;
               au <= g_st[k-1].au[UW+CHUNK-1:CHUNK];
               bu <= g_st[k-1].bu[UW+CHUNK-1:CHUNK];
            end
      end
   end
   if (NSTAGE == 1) begin : g_one
      assign fa   = a;
      assign fb   = be;
      assign fc   = sub;
      assign fv   = in_valid;
      assign fsub = sub;
      assign fsat = sat;
      assign raw  = top[CHUNK-1:0];
   end else begin : g_many
      assign fa   = g_st[NSTAGE-2].au;
      assign fb   = g_st[NSTAGE-2].bu;
      assign fc   = g_st[NSTAGE-2].c;
      assign fv   = g_st[NSTAGE-2].v;
      assign fsub = g_st[NSTAGE-2].sb;
      assign fsat = g_st[NSTAGE-2].st;
      assign raw  = {top[CHUNK-1:0], g_st[NSTAGE-2].ps};
   end
   assign top = {1'b0, fa} + {1'b0, fb} + {{CHUNK{1'b0}}, fc};
   assign fo  = (fa[CHUNK-1] == fb[CHUNK-1]) && (top[CHUNK-1] != fa[CHUNK-1]);
   // output stage: top slice, flags and optional clamp; data only moves on a valid transfer
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv) begin
         out_valid <= fv;
         if (fv) begin
            s    <= (fsat && fo) ? {fa[CHUNK-1], {(WIDTH-1){~fa[CHUNK-1]}}} : raw;
            cout <= top[CHUNK] ^ fsub;
            ovf  <= fo;
         end
      end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed + random scoreboard bench for pipelined_addsub
module tb_pipelined_addsub;
   typedef struct {
      logic [15:0] a, b;
      logic        sub, sat;
      logic [15:0] s;
      logic        c, o;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, sub, sat, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, s;
   int          total = 0;
   int          bad = 0;
   txn_t        sq[$];
   txn_t        q[$];
   logic        hold = 1'b0;
   logic [15:0] hs;
   logic        hc, ho;

   pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic txn_t dt(input logic [15:0] x, y, input logic su, sa,
                               input logic [15:0] es, input logic ec, eo);
      txn_t t;
      t.a = x; t.b = y; t.sub = su; t.sat = sa; t.s = es; t.c = ec; t.o = eo;
      return t;
   endfunction

   function automatic txn_t mk(input logic [15:0] x, y, input logic su, sa);
      txn_t        t;
      int          sx, sy, r;
      logic [16:0] u;
      sx = $signed(x);
      sy = $signed(y);
      r  = su ? sx - sy : sx + sy;
      u  = su ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
      t.a = x; t.b = y; t.sub = su; t.sat = sa;
      t.c = u[16];
      t.o = (r > 32767) || (r < -32768);
      t.s = (sa && t.o) ? ((r < 0) ? 16'h8000 : 16'h7FFF) : u[15:0];
      return t;
   endfunction

   function automatic txn_t rnd();
      return mk(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic drive(input txn_t t);
      a = t.a; b = t.b; sub = t.sub; sat = t.sat;
   endtask

   // single transaction into an empty pipe: out_valid exactly on the 4th edge, one cycle wide
   task automatic lat(input txn_t t);
      chk("lat_in_ready", {31'd0, in_ready}, 1);
      drive(t);
      in_valid = 1'b1;
      q.push_back(t);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("lat_out_valid", {31'd0, out_valid}, (i == 3) ? 1 : 0);
         @(posedge clk); #1;
      end
   endtask

   // stream sq with out_ready low in cycles lo..hi; want = cycles until the scoreboard drains
   task automatic run(input int lo, input int hi, input int want);
      int cyc = 0;
      while ((sq.size() > 0 || q.size() > 0) && cyc < 100) begin
         out_ready = !(cyc >= lo && cyc <= hi);
         in_valid  = sq.size() > 0;
         if (in_valid) drive(sq[0]);
         #1;
         if (in_valid && in_ready) q.push_back(sq.pop_front());
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("run_cycles", cyc, want);
   endtask

   // scoreboard compare, output hold while blocked, in_ready low while blocked
   always @(negedge clk) begin
      txn_t e;
      if (hold && !rst) begin
         total++;
         assert (s === hs && cout === hc && ovf === ho && out_valid === 1'b1) else begin
            bad++;
            $error("FAIL hold got s=%h c=%b o=%b v=%b want s=%h c=%b o=%b v=1", s, cout, ovf, out_valid, hs, hc, ho);
         end
      end
      if (out_valid && !out_ready) begin
         total++;
         assert (in_ready === 1'b0) else begin
            bad++;
            $error("FAIL stall_in_ready got=%b want=0", in_ready);
         end
      end
      if (out_valid && out_ready) begin
         total++;
         assert (q.size() > 0) else begin
            bad++;
            $error("FAIL extra_output got s=%h with empty scoreboard want none", s);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            assert ({s, cout, ovf} === {e.s, e.c, e.o}) else begin
               bad++;
               $error("FAIL result a=%h b=%h sub=%b sat=%b got s=%h c=%b o=%b want s=%h c=%b o=%b",
                      e.a, e.b, e.sub, e.sat, s, cout, ovf, e.s, e.c, e.o);
            end
         end
      end
      hold = out_valid && !out_ready && !rst;
      hs = s; hc = cout; ho = ovf;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0; sat = 1'b0;
      @(posedge clk); #1;
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_s", {16'd0, s}, 0);
      chk("rst_cout", {31'd0, cout}, 0);
      chk("rst_ovf", {31'd0, ovf}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      // basic add with latency check
      lat(dt(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0));
      // sign/borrow/overflow/saturation corners, back to back
      sq.push_back(dt(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0));
      sq.push_back(dt(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1));
      sq.push_back(dt(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1));
      sq.push_back(dt(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1));
      sq.push_back(dt(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
      sq.push_back(dt(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
      run(-1, -1, 10);
      // 8 random back to back
      for (int i = 0; i < 8; i++) sq.push_back(rnd());
      run(-1, -1, 12);
      // 6 random with the output blocked in cycles 5..9
      for (int i = 0; i < 6; i++) sq.push_back(rnd());
      run(5, 9, 15);
      chk("sb_empty_pre_rst", q.size(), 0);
      // asynchronous reset with three transactions in flight
      for (int i = 0; i < 3; i++) begin
         t = rnd();
         drive(t);
         in_valid = 1'b1;
         q.push_back(t);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_out_valid", {31'd0, out_valid}, 1);
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      chk("arst_out_valid", {31'd0, out_valid}, 0);
      chk("arst_s", {16'd0, s}, 0);
      chk("arst_cout", {31'd0, cout}, 0);
      chk("arst_ovf", {31'd0, ovf}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_no_stale", {31'd0, out_valid}, 0);
         @(posedge clk); #1;
      end
      lat(dt(16'h4000, 16'h4000, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1));
      chk("sb_empty_end", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
